// File: rtl/oled_pattern_gen.sv
// rtl/oled_pattern_gen.sv - selectable test-pattern colour source for the SPI OLED video path (optional feature macro: OLED_PATTERN_INVERT_EN)
module oled_pattern_gen #(
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 6,
  parameter int R_BITS      = 3,
  parameter int G_BITS      = 3,
  parameter int B_BITS      = 2,
  parameter int CHECK_SHIFT = 3,
  parameter int SCROLL_DIV  = 4,
  localparam int CW         = R_BITS + G_BITS + B_BITS
) (
  input  logic              clk,
  input  logic              rst,
`ifdef OLED_PATTERN_INVERT_EN
  input  logic              invert,
`endif
  input  logic [X_BITS-1:0] x,
  input  logic [Y_BITS-1:0] y,
  input  logic [1:0]        mode_in,
  input  logic [CW-1:0]     solid_in,
  input  logic              mode_valid,
  output logic              mode_ready,
  output logic [CW-1:0]     color,
  output logic              frame_tick,
  output logic [X_BITS-1:0] scroll
);

  localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int XYW   = (X_BITS > Y_BITS) ? X_BITS : Y_BITS;

  logic              at_origin;
  logic              at_origin_q;
  logic              frame_start;
  logic              accept;

  logic              pend_full;
  logic [1:0]        pend_mode;
  logic [CW-1:0]     pend_solid;
  logic [1:0]        act_mode;
  logic [CW-1:0]     act_base;
  logic [DIV_W-1:0]  div_cnt;

  logic [X_BITS-1:0] xs;
  logic [2:0]        bar;
  logic              chk_sel;
  logic [CW-1:0]     pix;

  assign at_origin   = (x == '0) && (y == '0);
  assign frame_start = at_origin && !at_origin_q;
  assign mode_ready  = !pend_full;
  assign accept      = mode_valid && mode_ready;

  // Edge-detect the origin so a coordinate parked at (0,0) yields a single frame tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      at_origin_q <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      at_origin_q <= at_origin;
      frame_tick  <= frame_start;
    end
  end

  // One-deep pending slot; its contents become active only at a frame start, never mid-frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_full  <= 1'b0;
      pend_mode  <= '0;
      pend_solid <= '0;
      act_mode   <= '0;
      act_base   <= '0;
    end else if (frame_start && pend_full) begin
      act_mode  <= pend_mode;
      act_base  <= pend_solid;
      pend_full <= 1'b0;
    end else if (accept) begin
      pend_mode  <= mode_in;
      pend_solid <= solid_in;
      pend_full  <= 1'b1;
    end
  end

  // Frame divider: scroll advances one column every SCROLL_DIV frames, wrapping naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      scroll  <= '0;
    end else if (frame_start) begin
      if (div_cnt == DIV_W'(SCROLL_DIV - 1)) begin
        div_cnt <= '0;
        scroll  <= scroll + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Pattern selection from the coordinate and the state that is active this cycle
  always_comb begin
    pix     = '0;
    xs      = x + scroll;
    bar     = xs[X_BITS-1 -: 3];
    chk_sel = |(((XYW'(x) >> CHECK_SHIFT) ^ (XYW'(y) >> CHECK_SHIFT)) & XYW'(1));
    case (act_mode)
      2'd0: pix = act_base;
      2'd1: pix = {{R_BITS{bar[2]}}, {G_BITS{bar[1]}}, {B_BITS{bar[0]}}};
      2'd2: pix = chk_sel ? ~act_base : act_base;
      default: pix = {x[X_BITS-1 -: R_BITS], y[Y_BITS-1 -: G_BITS], scroll[X_BITS-1 -: B_BITS]};
    endcase
  end

`ifdef OLED_PATTERN_INVERT_EN
  logic inv_q;

  // Invert request is sampled at frame start so a frame is never partially inverted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if (frame_start) begin
      inv_q <= invert;
    end
  end

  // Output register, optionally inverted for the whole frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color <= '0;
    end else begin
      color <= pix ^ {CW{inv_q}};
    end
  end
`else
  // Output register giving the one-cycle pixel latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color <= '0;
    end else begin
      color <= pix;
    end
  end
`endif

endmodule

// File: tb/tb_oled_pattern_gen.sv
// tb/tb_oled_pattern_gen.sv - scoreboard bench for oled_pattern_gen
module tb_oled_pattern_gen;

  logic       clk;
  logic       rst;
  logic [7:0] x;
  logic [5:0] y;
  logic [1:0] mode_in;
  logic [7:0] solid_in;
  logic       mode_valid;
  logic       mode_ready;
  logic [7:0] color;
  logic       frame_tick;
  logic [7:0] scroll;
`ifdef OLED_PATTERN_INVERT_EN
  logic       invert;
`endif

  oled_pattern_gen dut (
    .clk        (clk),
    .rst        (rst),
`ifdef OLED_PATTERN_INVERT_EN
    .invert     (invert),
`endif
    .x          (x),
    .y          (y),
    .mode_in    (mode_in),
    .solid_in   (solid_in),
    .mode_valid (mode_valid),
    .mode_ready (mode_ready),
    .color      (color),
    .frame_tick (frame_tick),
    .scroll     (scroll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int color;
    int tick;
    int scroll;
    int ready;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: frame count since reset, active pattern, pending request list
  int   m_mode, m_base, m_frames;
  bit   m_prev_origin, m_inv;
  int   pend_mode[$];
  int   pend_base[$];

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_base = 0; m_frames = 0;
    m_prev_origin = 0; m_inv = 0;
    pend_mode.delete();
    pend_base.delete();
  endtask

  function automatic int ref_pix(input int px, input int py);
    int sc, xs, bar, r;
    sc  = (m_frames / 4) % 256;
    xs  = (px + sc) % 256;
    bar = xs / 32;
    case (m_mode)
      0: r = m_base;
      1: r = ((bar / 4) % 2) * 224 + ((bar / 2) % 2) * 28 + (bar % 2) * 3;
      2: r = (((px / 8) + (py / 8)) % 2 == 1) ? 255 - m_base : m_base;
      default: r = (px / 32) * 32 + (py / 8) * 4 + sc / 64;
    endcase
    if (m_inv) r = 255 - r;
    return r;
  endfunction

  // Drive one pixel and push the response the model predicts for it
  task automatic cyc(input int px, input int py, input bit v, input int m, input int s, input bit inv);
    exp_t e;
    bit   origin, fs, acc;
    @(negedge clk);
    x          = 8'(px);
    y          = 6'(py);
    mode_valid = v;
    mode_in    = 2'(m);
    solid_in   = 8'(s);
`ifdef OLED_PATTERN_INVERT_EN
    invert     = inv;
`endif
    e.color = ref_pix(px, py);
    origin  = (px == 0) && (py == 0);
    fs      = origin && !m_prev_origin;
    m_prev_origin = origin;
    acc     = v && (pend_mode.size() == 0);
    if (fs) begin
      m_frames++;
      m_inv = inv;
      if (pend_mode.size() > 0) begin
        m_mode = pend_mode.pop_front();
        m_base = pend_base.pop_front();
      end
    end
    if (acc) begin
      pend_mode.push_back(m);
      pend_base.push_back(s);
    end
    e.tick   = fs ? 1 : 0;
    e.scroll = (m_frames / 4) % 256;
    e.ready  = (pend_mode.size() == 0) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mode_valid = 1'b0;
    x = 8'd5;
    y = 6'd3;
    rst = 1'b1;
    #1;
    check("rst_color", int'(color), 0);
    check("rst_tick", int'(frame_tick), 0);
    check("rst_scroll", int'(scroll), 0);
    check("rst_ready", int'(mode_ready), 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic frame();
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every output cycle with a pending prediction is compared
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("color", int'(color), e.color);
        check("frame_tick", int'(frame_tick), e.tick);
        check("scroll", int'(scroll), e.scroll);
        check("mode_ready", int'(mode_ready), e.ready);
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1;
    x = '0; y = '0; mode_in = '0; solid_in = '0; mode_valid = 1'b0;
`ifdef OLED_PATTERN_INVERT_EN
    invert = 1'b0;
`endif
    model_reset();
    do_reset();

    // solid, then a mid-frame request applied at the next frame
    cyc(5, 3, 0, 0, 0, 0);
    cyc(5, 3, 1, 0, 8'h02, 0);
    for (int i = 0; i < 3; i++) cyc(6 + i, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(2, 0, 0, 0, 0, 0);

    // bars sweep at scroll 0, then scroll 1
    cyc(10, 3, 1, 1, 0, 0);
    for (int i = 0; i < 256; i++) cyc(i, 0, 0, 0, 0, 0);
    frame();
    frame();
    cyc(31, 0, 0, 0, 0, 0);

    // checker
    cyc(10, 3, 1, 2, 8'hE0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(8, 0, 0, 0, 0, 0);
    cyc(8, 8, 0, 0, 0, 0);

    // gradient at scroll 0xC0, then a held origin
    cyc(10, 3, 1, 3, 0, 0);
    while (m_frames < 768) frame();
    cyc(8'hA0, 6'h3F, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);

    // reset with a request pending; it must never be applied
    cyc(3, 3, 1, 1, 8'h55, 0);
    cyc(4, 3, 0, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0, 0);
    cyc(7, 7, 0, 0, 0, 0);
    cyc(100, 9, 0, 0, 0, 0);

`ifdef OLED_PATTERN_INVERT_EN
    cyc(5, 5, 1, 0, 8'h02, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(5, 5, 0, 0, 0, 0);
    cyc(200, 40, 0, 0, 0, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int px, py, m, s;
      bit v, inv;
      px  = $urandom_range(0, 255);
      py  = $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) begin
        px = 0;
        py = 0;
      end
      v   = ($urandom_range(0, 3) == 0);
      m   = $urandom_range(0, 3);
      s   = $urandom_range(0, 255);
      inv = 1'b0;
`ifdef OLED_PATTERN_INVERT_EN
      inv = ($urandom_range(0, 1) == 1);
`endif
      cyc(px, py, v, m, s, inv);
    end

    k = 0;
    while (sb.size() > 0 && k < 10) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d predictions left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
